cdc_c2g_tx: RTL



---
 rtl/cdc_pkg.sv | 25 ++
 rtl/cdc_phase_cnt.sv | 33 +++
 rtl/cdc_c2g_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdc_pkg : shared types and widths for the camera-to-g_clk result CDC      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package cdc_pkg;

  localparam int CDC_DATASIZE  = 16;
  localparam int CDC_COUNTSIZE = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ASSERT = 2'd2,
    GAP    = 2'd3
  } cdc_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_phase_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdc_phase_cnt : loadable down-counter, done while the count is zero       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cdc_phase_cnt
  import cdc_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/cdc_c2g_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdc_c2g_tx : camera-side transmitter, holds result buses and pulses       |
// | detect low-high-low. Optional pending slot: CDC_C2G_PEND_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module cdc_c2g_tx
  import cdc_pkg::*;
#(
  parameter int DATASIZE  = CDC_DATASIZE,
  parameter int COUNTSIZE = CDC_COUNTSIZE,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4,
  parameter int GAP_CYC   = 4,
  parameter int DROPSIZE  = 8
) (
  input  logic                 c_clk,
  input  logic                 c_rst_n,
  input  logic                 c_req,
  input  logic [DATASIZE-1:0]  c_diff,
  input  logic [COUNTSIZE-1:0] c_diff_count,
  output logic                 c_ready,
  output logic                 c_detect_c2g,
  output logic [DATASIZE-1:0]  c_diff_c2g,
  output logic [COUNTSIZE-1:0] c_diff_count_c2g,
  output logic [DROPSIZE-1:0]  c_drop_count
);

  localparam int MAX_PHASE = max3(SETUP_CYC, HOLD_CYC, GAP_CYC);
  localparam int CW        = $clog2(MAX_PHASE + 1);

  // Counter is loaded with length-1 so done fires in the last cycle of a phase
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

  cdc_state_t            state_q, state_d;
  logic                  cnt_done;
  logic                  cnt_load;
  logic [CW-1:0]         cnt_val;
  logic                  detect_q, detect_d;
  logic [DATASIZE-1:0]   diff_q;
  logic [COUNTSIZE-1:0]  count_q;
  logic [DROPSIZE-1:0]   drop_q;
  logic                  load;
  logic [DATASIZE-1:0]   load_diff;
  logic [COUNTSIZE-1:0]  load_count;
  logic                  drop;

  cdc_phase_cnt #(
    .WIDTH (CW)
  ) u_phase_cnt (
    .clk_i      (c_clk),
    .rst_ni     (c_rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  always_ff @(posedge c_clk or negedge c_rst_n) begin
    if (!c_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load)     state_d = SETUP;
      SETUP:   if (cnt_done) state_d = ASSERT;
      ASSERT:  if (cnt_done) state_d = GAP;
      GAP:     if (cnt_done) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (state_d != state_q) begin
      case (state_d)
        SETUP:   begin cnt_load = 1'b1; cnt_val = SETUP_LD; end
        ASSERT:  begin cnt_load = 1'b1; cnt_val = HOLD_LD;  end
        GAP:     begin cnt_load = 1'b1; cnt_val = GAP_LD;   end
        default: begin cnt_load = 1'b0; cnt_val = '0;       end
      endcase
    end
    detect_d = (state_d == ASSERT);
  end

`ifdef CDC_C2G_PEND_EN
  logic                 pend_valid_q, pend_valid_d;
  logic [DATASIZE-1:0]  pend_diff_q, pend_diff_d;
  logic [COUNTSIZE-1:0] pend_count_q, pend_count_d;

  // In IDLE the pending entry wins; a same-cycle request refills the slot
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_diff_d  = pend_diff_q;
    pend_count_d = pend_count_q;
    load         = 1'b0;
    load_diff    = c_diff;
    load_count   = c_diff_count;
    if (state_q == IDLE) begin
      if (pend_valid_q) begin
        load         = 1'b1;
        load_diff    = pend_diff_q;
        load_count   = pend_count_q;
        pend_valid_d = c_req;
        if (c_req) begin
          pend_diff_d  = c_diff;
          pend_count_d = c_diff_count;
        end
      end else if (c_req) begin
        load = 1'b1;
      end
    end else if (c_req && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_diff_d  = c_diff;
      pend_count_d = c_diff_count;
    end
  end

  always_ff @(posedge c_clk or negedge c_rst_n) begin
    if (!c_rst_n) begin
      pend_valid_q <= 1'b0;
      pend_diff_q  <= '0;
      pend_count_q <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_diff_q  <= pend_diff_d;
      pend_count_q <= pend_count_d;
    end
  end

  assign c_ready = !pend_valid_q || (state_q == IDLE);
`else
  always_comb begin
    load       = (state_q == IDLE) && c_req;
    load_diff  = c_diff;
    load_count = c_diff_count;
  end

  assign c_ready = (state_q == IDLE);
`endif

  assign drop = c_req && !c_ready;

  always_ff @(posedge c_clk or negedge c_rst_n) begin
    if (!c_rst_n) begin
      detect_q <= 1'b0;
      diff_q   <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      detect_q <= detect_d;
      if (load) begin
        diff_q  <= load_diff;
        count_q <= load_count;
      end
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + DROPSIZE'(1);
      end
    end
  end

  assign c_detect_c2g     = detect_q;
  assign c_diff_c2g       = diff_q;
  assign c_diff_count_c2g = count_q;
  assign c_drop_count     = drop_q;

endmodule
`default_nettype wire
